dmem_responder: RTL and testbench

- Memory-side responder for the execute stage's memory strobes (readEnable, writeEnable, Address, storeData).
- Serves a synchronous word RAM plus a small memory-mapped I/O window:
  - display register
  - DIP switches
  - free-running cycle counter
- Returns load data to the writeback stage with fixed one-cycle latency.
- Drives a time-multiplexed 4-digit seven-segment display from the display register.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_responder_seg_scanner.sv | 54 +++++
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder and display logic.
// seg_encode is also reused by the pipeline LED logic.
package dmem_pkg;

   localparam int unsigned DEFAULT_AW = 12;

   localparam logic [15:0] DISP_ADDR  = 16'hFFF0;
   localparam logic [15:0] DIPSW_ADDR = 16'hFFF1;
   localparam logic [15:0] CYCLE_ADDR = 16'hFFF2;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_DISP,
      REG_DIPSW,
      REG_CYCLE,
      REG_NONE
   } region_e;

   // Segment pattern: bit7 = a ... bit1 = g, bit0 = dp (never lit).
   function automatic logic [7:0] seg_encode(input logic [3:0] nib);
      logic [7:0] pat;
      case (nib)
         4'h0: pat = 8'hFC;
         4'h1: pat = 8'h60;
         4'h2: pat = 8'hDA;
         4'h3: pat = 8'hF2;
         4'h4: pat = 8'h66;
         4'h5: pat = 8'hB6;
         4'h6: pat = 8'hBE;
         4'h7: pat = 8'hE0;
         4'h8: pat = 8'hFE;
         4'h9: pat = 8'hF6;
         4'hA: pat = 8'hEE;
         4'hB: pat = 8'h3E;
         4'hC: pat = 8'h1A;
         4'hD: pat = 8'h7A;
         4'hE: pat = 8'h9E;
         default: pat = 8'h8E;
      endcase
      return pat;
   endfunction

   function automatic region_e addr_decode(input logic [15:0] addr, input int unsigned aw);
      region_e reg_sel;
      if ((addr >> aw) == 16'd0)    reg_sel = REG_RAM;
      else if (addr == DISP_ADDR)   reg_sel = REG_DISP;
      else if (addr == DIPSW_ADDR)  reg_sel = REG_DIPSW;
      else if (addr == CYCLE_ADDR)  reg_sel = REG_CYCLE;
      else                          reg_sel = REG_NONE;
      return reg_sel;
   endfunction

endpackage

// File: rtl/dmem_responder_seg_scanner.sv
// Time-multiplexes a 16-bit value onto a 4-digit seven-segment display,
// leftmost digit first, each digit lit for SCAN_DIV cycles.
module seg_scanner
   import dmem_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   output logic [7:0]  seg,
   output logic [3:0]  digit_sel
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0] r_scan_cnt;
   logic [1:0]    r_idx;
   logic [7:0]    r_seg;
   logic [3:0]    r_digit_sel;
   logic          w_wrap;
   logic [3:0]    w_nibble;

   assign w_wrap = (r_scan_cnt == CW'(SCAN_DIV - 1));

   always_comb begin
      w_nibble = value[3:0];
      case (r_idx)
         2'd0:    w_nibble = value[15:12];
         2'd1:    w_nibble = value[11:8];
         2'd2:    w_nibble = value[7:4];
         default: w_nibble = value[3:0];
      endcase
   end

   // Outputs follow the live value so a DISP write shows on the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt  <= '0;
         r_idx       <= 2'd0;
         r_seg       <= 8'h00;
         r_digit_sel <= 4'b0000;
      end else begin
         r_scan_cnt  <= w_wrap ? '0 : r_scan_cnt + CW'(1);
         if (w_wrap) r_idx <= r_idx + 2'd1;
         r_seg       <= seg_encode(w_nibble);
         r_digit_sel <= 4'b1000 >> r_idx;
      end
   end

   assign seg       = r_seg;
   assign digit_sel = r_digit_sel;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: word RAM plus DISP/DIPSW/CYCLE I/O window,
// one-cycle load latency, and the seven-segment scanner for DISP.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned AW       = DEFAULT_AW,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        readEnable,
   input  logic        writeEnable,
   input  logic [15:0] Address,
   input  logic [15:0] storeData,
   input  logic [15:0] dipswitch,
   output logic [15:0] loadData,
   output logic        loadValid,
   output logic        err,
   output logic [7:0]  seg,
   output logic [3:0]  digit_sel,
   output logic [15:0] disp_value
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [15:0] r_mem [0:DEPTH-1];
   logic [15:0] r_ram_q;
   logic [15:0] r_io_q;
   logic [15:0] r_disp;
   logic [15:0] r_cycle;
   logic        r_sel_ram;
   logic        r_load_valid;
   logic        r_err;

   region_e     w_region;
   logic        w_rd_ok;
   logic        w_ram_rd;
   logic        w_ram_wr;
   logic [AW-1:0] w_ram_addr;
   logic [15:0] w_io_data;

   assign w_region   = addr_decode(Address, AW);
   assign w_rd_ok    = readEnable & ~writeEnable;
   assign w_ram_addr = Address[AW-1:0];
   assign w_ram_rd   = w_rd_ok & (w_region == REG_RAM);
   assign w_ram_wr   = writeEnable & (w_region == REG_RAM);

   always_comb begin
      w_io_data = 16'h0000;
      case (w_region)
         REG_DISP:  w_io_data = r_disp;
         REG_DIPSW: w_io_data = dipswitch;
         REG_CYCLE: w_io_data = r_cycle;
         default:   w_io_data = 16'h0000;
      endcase
   end

   // Block RAM: no reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      if (w_ram_wr) r_mem[w_ram_addr] <= storeData;
      if (w_ram_rd) r_ram_q <= r_mem[w_ram_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle      <= 16'h0000;
         r_disp       <= 16'h0000;
         r_io_q       <= 16'h0000;
         r_sel_ram    <= 1'b0;
         r_load_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_cycle      <= r_cycle + 16'd1;
         r_load_valid <= w_rd_ok;
         r_err        <= readEnable & writeEnable;
         if (w_rd_ok) begin
            r_sel_ram <= (w_region == REG_RAM);
            r_io_q    <= w_io_data;
         end
         if (writeEnable && (w_region == REG_DISP)) r_disp <= storeData;
      end
   end

   // Select is only updated on accepted reads, so loadData holds between loads.
   assign loadData   = r_sel_ram ? r_ram_q : r_io_q;
   assign loadValid  = r_load_valid;
   assign err        = r_err;
   assign disp_value = r_disp;

   seg_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .value     (r_disp),
      .seg       (seg),
      .digit_sel (digit_sel)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a behavioural
// model of the address map, load latency, cycle counter and display scan.
module tb_dmem_responder;

   localparam int SCAN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        readEnable = 1'b0;
   logic        writeEnable = 1'b0;
   logic [15:0] Address = 16'h0000;
   logic [15:0] storeData = 16'h0000;
   logic [15:0] dipswitch = 16'h0000;
   logic [15:0] loadData;
   logic        loadValid;
   logic        err;
   logic [7:0]  seg;
   logic [3:0]  digit_sel;
   logic [15:0] disp_value;

   always #5 clk = ~clk;

   dmem_responder #(
      .AW       (12),
      .SCAN_DIV (SCAN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .readEnable  (readEnable),
      .writeEnable (writeEnable),
      .Address     (Address),
      .storeData   (storeData),
      .dipswitch   (dipswitch),
      .loadData    (loadData),
      .loadValid   (loadValid),
      .err         (err),
      .seg         (seg),
      .digit_sel   (digit_sel),
      .disp_value  (disp_value)
   );

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

   // Reference state
   logic [15:0] mem_m [4096];
   bit          mem_k [4096];
   logic [15:0] disp_m;
   logic [15:0] cyc_m;
   int          scan_n;
   bit          exp_valid, exp_err, exp_known;
   logic [15:0] exp_data;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_dsel;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      disp_m = 16'h0000; cyc_m = 16'h0000; scan_n = 0;
      exp_valid = 0; exp_err = 0; exp_known = 1; exp_data = 16'h0000;
      exp_seg = 8'h00; exp_dsel = 4'b0000;
   endtask

   task automatic do_reset();
      readEnable = 0; writeEnable = 0;
      #2;
      rst_n = 0;
      #1;
      chk("rst_seg", {8'h00, seg}, 16'h0000);
      chk("rst_dsel", {12'h000, digit_sel}, 16'h0000);
      chk("rst_valid", {15'h0, loadValid}, 16'h0000);
      chk("rst_err", {15'h0, err}, 16'h0000);
      chk("rst_load", loadData, 16'h0000);
      chk("rst_disp", disp_value, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   // Called at a negedge: drive one request, predict the next edge, then check.
   task automatic step(input logic re, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] dip);
      logic [15:0] rd;
      logic [3:0]  nib;
      bit          rk;
      int          dig;
      readEnable = re; writeEnable = we; Address = addr; storeData = wd; dipswitch = dip;
      if (re || we)
         $display("t=%0t re=%0b we=%0b addr=%h wdata=%h dip=%h", $time, re, we, addr, wd, dip);
      rk = 1;
      if (addr < 16'h1000) begin
         rd = mem_m[addr[11:0]]; rk = mem_k[addr[11:0]];
      end else if (addr == 16'hFFF0) rd = disp_m;
      else if (addr == 16'hFFF1) rd = dip;
      else if (addr == 16'hFFF2) rd = cyc_m;
      else rd = 16'h0000;
      scan_n++;
      dig = ((scan_n - 1) / SCAN) % 4;
      nib = 4'((disp_m >> (12 - 4 * dig)) & 16'hF);
      exp_seg = seg_tab[nib];
      exp_dsel = 4'b1000 >> dig;
      exp_valid = re && !we;
      if (exp_valid) begin
         exp_data = rd; exp_known = rk;
      end
      exp_err = re && we;
      if (we) begin
         if (addr < 16'h1000) begin
            mem_m[addr[11:0]] = wd; mem_k[addr[11:0]] = 1;
         end else if (addr == 16'hFFF0) disp_m = wd;
      end
      cyc_m = cyc_m + 16'd1;
      @(negedge clk);
      chk("loadValid", {15'h0, loadValid}, {15'h0, exp_valid});
      if (exp_known) chk("loadData", loadData, exp_data);
      chk("err", {15'h0, err}, {15'h0, exp_err});
      chk("seg", {8'h00, seg}, {8'h00, exp_seg});
      chk("digit_sel", {12'h000, digit_sel}, {12'h000, exp_dsel});
      chk("disp_value", disp_value, disp_m);
   endtask

   initial begin
      int k;
      logic [15:0] a;
      for (int i = 0; i < 4096; i++) begin
         mem_m[i] = 16'h0000; mem_k[i] = 0;
      end
      model_reset();
      do_reset();

      // Write then read back
      step(0, 1, 16'h0005, 16'h1234, 16'h0000);
      step(1, 0, 16'h0005, 16'h0000, 16'h0000);
      step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      // Back-to-back reads
      step(0, 1, 16'h0001, 16'h000A, 16'h0000);
      step(0, 1, 16'h0002, 16'h000B, 16'h0000);
      step(0, 1, 16'h0003, 16'h000C, 16'h0000);
      step(1, 0, 16'h0001, 16'h0000, 16'h0000);
      step(1, 0, 16'h0002, 16'h0000, 16'h0000);
      step(1, 0, 16'h0003, 16'h0000, 16'h0000);
      step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      // Illegal both-enables
      step(1, 1, 16'h0010, 16'h5555, 16'h0000);
      step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      step(1, 0, 16'h0010, 16'h0000, 16'h0000);
      // I/O window
      step(1, 0, 16'hFFF1, 16'h0000, 16'hBEEF);
      step(0, 1, 16'hFFF1, 16'h0000, 16'hBEEF);
      step(1, 0, 16'hFFF1, 16'h0000, 16'hBEEF);
      step(0, 1, 16'hFFF7, 16'h7777, 16'hBEEF);
      step(1, 0, 16'hFFF7, 16'h0000, 16'hBEEF);
      step(0, 1, 16'hFFF2, 16'h4444, 16'hBEEF);
      // Display scan
      step(0, 1, 16'hFFF0, 16'h0F2A, 16'h0000);
      step(1, 0, 16'hFFF0, 16'h0000, 16'h0000);
      repeat (21) step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      step(0, 1, 16'hFFF0, 16'h9C31, 16'h0000);
      repeat (6) step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      // Reset mid-scan, then CYCLE read 10 cycles after release
      step(1, 0, 16'h0001, 16'h0000, 16'h0000);
      do_reset();
      repeat (10) step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      step(1, 0, 16'hFFF2, 16'h0000, 16'h0000);
      step(1, 0, 16'h0005, 16'h0000, 16'h0000);

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         k = $urandom_range(0, 9);
         if (k < 6)       a = 16'($urandom_range(0, 31));
         else if (k == 6) a = 16'hFFF0;
         else if (k == 7) a = 16'hFFF1;
         else if (k == 8) a = 16'hFFF2;
         else             a = 16'($urandom_range(16'h1000, 16'hFFEF));
         k = $urandom_range(0, 9);
         step(k < 4 || k == 7, k >= 4 && k <= 7, a, 16'($urandom), 16'($urandom));
      end

      // Counter wrap
      while (cyc_m != 16'hFFFF) step(0, 0, 16'h0000, 16'h0000, 16'h0000);
      step(1, 0, 16'hFFF2, 16'h0000, 16'h0000);
      step(1, 0, 16'hFFF2, 16'h0000, 16'h0000);
      step(0, 0, 16'h0000, 16'h0000, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
